// File: rtl/cdf_top_if.sv
// rtl/cdf_top_if.sv - histogram read / scratch write memory port bundle for cdf_top
interface cdf_top_if;
  logic [15:0]  hist_mem_rd_addr;
  logic [127:0] hist_mem_rd_data;
  logic [127:0] sc_mem_wt_data;
  logic [15:0]  sc_mem_wt_addr;
  logic         sc_mem_wt_en;

  modport master (
    output hist_mem_rd_addr,
    input  hist_mem_rd_data,
    output sc_mem_wt_data,
    output sc_mem_wt_addr,
    output sc_mem_wt_en
  );

  modport slave (
    input  hist_mem_rd_addr,
    output hist_mem_rd_data,
    input  sc_mem_wt_data,
    input  sc_mem_wt_addr,
    input  sc_mem_wt_en
  );
endinterface

// File: rtl/cdf_top.sv
// rtl/cdf_top.sv - histogram prefix-sum (CDF) stage with cdf_min extraction
// Optional feature macro CDF_SAT_EN: partial sums saturate at 32'hFFFF_FFFF instead of wrapping.
module cdf_top #(
  parameter int          NUM_WORDS = 64,
  parameter logic [15:0] HIST_BASE = 16'h0000,
  parameter logic [15:0] SC_BASE   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  cdf_top_if.master   mem,
  output logic [31:0] cdf_min,
  output logic        cdf_InProgress,
  output logic        cdf_done
);
  localparam int CW = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  rd_cnt_q;
  logic [15:0]    rd_addr_q;
  logic           busy_q, done_q;

  logic [31:0]    sum_q, sum_d;
  logic [31:0]    min_q, min_d;
  logic           found_q, found_d;
  logic           rd_vld_q, rd_vld_d;
  logic           wt_en_q, wt_en_d;
  logic [15:0]    wt_addr_q, wt_addr_d;
  logic [127:0]   wt_data_q, wt_data_d;
  logic [CW-1:0]  wr_cnt_q, wr_cnt_d;

  logic           start;
  logic [31:0]    acc;
  logic [127:0]   cdf_word;

  function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
`ifdef CDF_SAT_EN
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
    return a + b;
`endif
  endfunction

  assign start = (state_q == IDLE) && enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q   <= READ;
            busy_q    <= 1'b1;
            rd_cnt_q  <= '0;
            rd_addr_q <= HIST_BASE;
          end
        end
        READ: begin
          if (rd_cnt_q == CW'(NUM_WORDS - 1)) begin
            state_q   <= DRAIN;
            rd_addr_q <= HIST_BASE;
          end else begin
            rd_cnt_q  <= rd_cnt_q + 1'b1;
            rd_addr_q <= HIST_BASE + 16'(rd_cnt_q) + 16'd1;
          end
        end
        DRAIN: begin
          // The write visible this cycle is the final word once all NUM_WORDS are counted.
          if (wt_en_q && (wr_cnt_q == CW'(NUM_WORDS))) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    sum_d     = sum_q;
    min_d     = min_q;
    found_d   = found_q;
    rd_vld_d  = (state_q == READ);
    wt_en_d   = rd_vld_q;
    wt_addr_d = wt_addr_q;
    wt_data_d = wt_data_q;
    wr_cnt_d  = wr_cnt_q;
    cdf_word  = '0;
    acc       = sum_q;
    for (int i = 0; i < 4; i++) begin
      acc = add32(acc, mem.hist_mem_rd_data[32*i +: 32]);
      cdf_word[32*i +: 32] = acc;
      if (rd_vld_q && !found_d && (acc != 32'd0)) begin
        found_d = 1'b1;
        min_d   = acc;
      end
    end
    if (rd_vld_q) begin
      sum_d     = acc;
      wt_data_d = cdf_word;
      wt_addr_d = SC_BASE + 16'(wr_cnt_q);
      wr_cnt_d  = wr_cnt_q + 1'b1;
    end
    if (start) begin
      sum_d    = '0;
      min_d    = '0;
      found_d  = 1'b0;
      wr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q     <= '0;
      min_q     <= '0;
      found_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      wt_en_q   <= 1'b0;
      wt_addr_q <= '0;
      wt_data_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      sum_q     <= sum_d;
      min_q     <= min_d;
      found_q   <= found_d;
      rd_vld_q  <= rd_vld_d;
      wt_en_q   <= wt_en_d;
      wt_addr_q <= wt_addr_d;
      wt_data_q <= wt_data_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign mem.hist_mem_rd_addr = rd_addr_q;
  assign mem.sc_mem_wt_data   = wt_data_q;
  assign mem.sc_mem_wt_addr   = wt_addr_q;
  assign mem.sc_mem_wt_en     = wt_en_q;
  assign cdf_min              = min_q;
  assign cdf_InProgress       = busy_q;
  assign cdf_done             = done_q;
endmodule

// File: tb/tb_cdf_top.sv
// tb/tb_cdf_top.sv - directed bench for cdf_top with a registered histogram memory model
module tb_cdf_top;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] cdf_min;
  logic        cdf_InProgress;
  logic        cdf_done;

  cdf_top_if mem_if ();

  cdf_top dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .mem            (mem_if),
    .cdf_min        (cdf_min),
    .cdf_InProgress (cdf_InProgress),
    .cdf_done       (cdf_done)
  );

  always #5 clk = ~clk;

  logic [127:0] hist [64];
  logic [127:0] exp_w [64];
  logic [31:0]  exp_min;
  logic [127:0] cap [64];

  always @(posedge clk) mem_if.hist_mem_rd_data <= hist[mem_if.hist_mem_rd_addr[5:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int t0, rel_m, rel_t, wcnt, dcnt, first_w, last_w, done_rel, oob, w_before;
  bit mon_on = 1'b0;
  logic ip1, ip66, ip67;
  logic [15:0] addr1;

  always @(negedge clk) begin
    if (mon_on) begin
      rel_m = cyc - t0;
      if (mem_if.sc_mem_wt_en === 1'b1) begin
        if (wcnt == 0) first_w = rel_m;
        last_w = rel_m;
        wcnt++;
        if (mem_if.sc_mem_wt_addr > 16'd63) oob++;
        cap[mem_if.sc_mem_wt_addr[5:0]] = mem_if.sc_mem_wt_data;
      end
      if (cdf_done === 1'b1) begin
        dcnt++;
        done_rel = rel_m;
      end
      if (rel_m == 1) begin
        ip1   = cdf_InProgress;
        addr1 = mem_if.hist_mem_rd_addr;
      end
      if (rel_m == 66) ip66 = cdf_InProgress;
      if (rel_m == 67) ip67 = cdf_InProgress;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: all ones; 1: only bin 10 = 5; 2: all zero; 3: bin0 = max, bin1 = 2
  task automatic fill(input int mode);
    logic [31:0] s, b;
    s = 32'd0;
    exp_min = 32'd0;
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < 4; i++) begin
        case (mode)
          0:       b = 32'd1;
          1:       b = (4*k + i == 10) ? 32'd5 : 32'd0;
          3:       b = (4*k + i == 0) ? 32'hFFFF_FFFF : ((4*k + i == 1) ? 32'd2 : 32'd0);
          default: b = 32'd0;
        endcase
        hist[k][32*i +: 32] = b;
`ifdef CDF_SAT_EN
        s = ({1'b0, s} + {1'b0, b} > 33'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : s + b;
`else
        s = s + b;
`endif
        exp_w[k][32*i +: 32] = s;
        if (exp_min == 32'd0) exp_min = s;
      end
    end
  endtask

  task automatic start_run();
    wcnt = 0; dcnt = 0; first_w = -1; last_w = -1; done_rel = -1; oob = 0;
    ip1 = 1'bx; ip66 = 1'bx; ip67 = 1'bx; addr1 = 'x;
    for (int k = 0; k < 64; k++) cap[k] = 'x;
    @(negedge clk);
    enable = 1'b1;
    t0 = cyc;
    mon_on = 1'b1;
  endtask

  task automatic run_full(input bit repulse);
    start_run();
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      rel_t = cyc - t0;
      enable = repulse && (rel_t == 10 || rel_t == 67);
    end
    mon_on = 1'b0;
  endtask

  task automatic check_run(input string name);
    chk({name, ".writes"}, wcnt, 64);
    chk({name, ".done_cnt"}, dcnt, 1);
    chk({name, ".first_wr_cyc"}, first_w, 3);
    chk({name, ".last_wr_cyc"}, last_w, 66);
    chk({name, ".done_cyc"}, done_rel, 67);
    chk({name, ".inprog_c1"}, ip1, 1'b1);
    chk({name, ".inprog_c66"}, ip66, 1'b1);
    chk({name, ".inprog_c67"}, ip67, 1'b0);
    chk({name, ".rd_addr_c1"}, addr1, 16'h0000);
    chk({name, ".wr_addr_oob"}, oob, 0);
    chk({name, ".cdf_min"}, cdf_min, exp_min);
    for (int k = 0; k < 64; k++) chk($sformatf("%s.word%0d", name, k), cap[k], exp_w[k]);
  endtask

  initial begin
    for (int k = 0; k < 64; k++) hist[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst.cdf_min", cdf_min, 32'd0);
    chk("rst.inprog", cdf_InProgress, 1'b0);
    chk("rst.done", cdf_done, 1'b0);
    chk("rst.wt_en", mem_if.sc_mem_wt_en, 1'b0);
    chk("rst.rd_addr", mem_if.hist_mem_rd_addr, 16'h0000);
    chk("rst.wt_addr", mem_if.sc_mem_wt_addr, 16'h0000);
    chk("rst.wt_data", mem_if.sc_mem_wt_data, 128'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    fill(0);
    run_full(1'b0);
    check_run("ones");
    chk("ones.word0_hand", cap[0], {32'd4, 32'd3, 32'd2, 32'd1});
    chk("ones.word63_hand", cap[63], {32'd256, 32'd255, 32'd254, 32'd253});
    chk("ones.min_hand", cdf_min, 32'd1);
    chk("ones.hold_data", mem_if.sc_mem_wt_data, {32'd256, 32'd255, 32'd254, 32'd253});

    fill(1);
    run_full(1'b0);
    check_run("bin10");
    chk("bin10.word1_hand", cap[1], 128'd0);
    chk("bin10.word2_hand", cap[2], {32'd5, 32'd5, 32'd0, 32'd0});
    chk("bin10.word40_hand", cap[40], {32'd5, 32'd5, 32'd5, 32'd5});
    chk("bin10.min_hand", cdf_min, 32'd5);

    fill(2);
    run_full(1'b0);
    check_run("zero");
    chk("zero.min_hand", cdf_min, 32'd0);

    fill(0);
    start_run();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      enable = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("arst.wt_en", mem_if.sc_mem_wt_en, 1'b0);
    chk("arst.inprog", cdf_InProgress, 1'b0);
    chk("arst.cdf_min", cdf_min, 32'd0);
    w_before = wcnt;
    repeat (5) @(negedge clk);
    chk("arst.no_writes", wcnt, w_before);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst.idle_inprog", cdf_InProgress, 1'b0);
    chk("arst.idle_writes", wcnt, w_before);
    mon_on = 1'b0;
    run_full(1'b0);
    check_run("after_rst");

    fill(0);
    run_full(1'b1);
    check_run("repulse");

    fill(3);
    run_full(1'b0);
    check_run("ovf");
`ifdef CDF_SAT_EN
    chk("ovf.c1_hand", cap[0][63:32], 32'hFFFF_FFFF);
`else
    chk("ovf.c1_hand", cap[0][63:32], 32'd1);
`endif
    chk("ovf.min_hand", cdf_min, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdf_top.md
# cdf_top

Cumulative-distribution stage of the histogram-equalization pipeline, sitting directly upstream of the divider/mapping stage. On a start pulse it streams the 256-bin histogram from histogram memory, forms the running prefix sum, and writes the CDF into scratch memory in the same 4-bins-per-word layout. It also extracts `cdf_min`, the first non-zero CDF value, which the downstream divider consumes. Throughput is one 128-bit word per cycle.

## Interface
Parameters:
- `NUM_WORDS`, 64: histogram words; 4 × 32-bit bins per word.
- `HIST_BASE`, 16'h0000: first histogram memory address.
- `SC_BASE`, 16'h0000: first scratch memory address for CDF output.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  start request; sampled only in IDLE.
- `hist_mem_rd_data`  in  128  histogram word; bin 4k+i in bits [32i+31:32i]; valid one cycle after its address.
- `hist_mem_rd_addr`  out  16  histogram read address.
- `sc_mem_wt_data`  out  128  CDF word, same bin packing.
- `sc_mem_wt_addr`  out  16  scratch write address.
- `sc_mem_wt_en`  out  1  scratch write strobe.
- `cdf_min`  out  32  first non-zero CDF value; 0 if none.
- `cdf_InProgress`  out  1  high while the block owns the memories.
- `cdf_done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: waits for `enable`=1. On start it clears the running sum, `cdf_min`, and the found flag, then goes to READ.
- READ: drives `hist_mem_rd_addr` = HIST_BASE + rd_cnt and increments rd_cnt each cycle. After address NUM_WORDS-1 it goes to DRAIN.
- DRAIN: waits until the last word is written, then goes to DONE.
- DONE: pulses `cdf_done` for one cycle, then returns to IDLE.
- Accumulate, combinational on returned data:
  - c0 = S + b0, c1 = c0 + b1, c2 = c1 + b2, c3 = c2 + b3.
  - S becomes c3.
  - The result is registered into `sc_mem_wt_data` and `sc_mem_wt_addr` = SC_BASE + wr_cnt, with `sc_mem_wt_en`=1.
- Arithmetic is 32-bit unsigned and wraps modulo 2^32 by default (see Configuration).
- `cdf_min` capture:
  - Scan order is c0..c3, word 0 first.
  - The first ci ≠ 0 is latched and the found flag is set; later values are ignored.
  - If no value is non-zero, `cdf_min` stays 0.
- `enable` is ignored outside IDLE. A start in the same cycle as `cdf_done` is not accepted; it takes effect one cycle later, in IDLE.
- `cdf_min` and the last write data hold their values until the next start.

## Timing
- Reset values: all outputs are 0, FSM is IDLE, and the sum, counters, and found flag are cleared.
- Cycle 0: `enable`=1 sampled in IDLE.
- Cycle 1: `cdf_InProgress`=1 and `hist_mem_rd_addr`=HIST_BASE.
- Cycle k+1: read address k.
- Cycle k+2: data for word k arrives.
- Cycle k+3: `sc_mem_wt_en`=1 for word k.
- Last write is at cycle NUM_WORDS+2 (66 by default).
- Cycle NUM_WORDS+3 (67): `cdf_done`=1, `cdf_InProgress`=0, and `cdf_min` is final.
- `cdf_InProgress` is high from cycle 1 through the last write cycle inclusive.
- `hist_mem_rd_addr` returns to HIST_BASE when the FSM leaves READ.
- Reset asserted mid-run:
  - Outputs go to 0 immediately (asynchronous), and no further writes occur.
  - After release the block is in IDLE and requires a fresh `enable`.
- The write address never exceeds SC_BASE + NUM_WORDS - 1. There is no wrap of the counters within a run.

## Configuration
- `CDF_SAT_EN` defined: each partial sum saturates at 32'hFFFF_FFFF instead of wrapping. Once saturated, the running sum stays at 32'hFFFF_FFFF.
- `CDF_SAT_EN` undefined: modulo-2^32 wrap, with no overflow indication.

## Test plan
- Every bin = 1, start at cycle 0:
  - Word k written = {4k+4, 4k+3, 4k+2, 4k+1}, one write per cycle on cycles 3..66.
  - `cdf_min`=1.
  - `cdf_done` pulses at cycle 67.
- Bins 0–9 = 0, bin 10 = 5, rest = 0: `cdf_min`=5, and every word from word 2 onward holds 5 in all bins from bin 10 up.
- All bins 0: all 64 words are written as 0, `cdf_min`=0, and `cdf_done` still pulses at cycle 67.
- `reset` low at cycle 20:
  - `sc_mem_wt_en`, `cdf_InProgress`, and `cdf_min` drop to 0 immediately, and no writes occur while in reset.
  - A new `enable` gives a full, correct run.
- `enable` re-pulsed at cycles 10 and 67: both ignored, with exactly 64 writes and one `cdf_done`.
- bin0 = 32'hFFFF_FFFF, bin1 = 2:
  - Without `CDF_SAT_EN`: c1 = 1.
  - With `CDF_SAT_EN`: c1 = 32'hFFFF_FFFF.
  - `cdf_min` = 32'hFFFF_FFFF in both builds.
